// File: rtl/rf_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_ctrl_pkg
// Description : Shared sizes and types for the register-file write control
//               slice (writeback arbiter, busy scoreboard).
// Contents    : DATA_W, ADDR_W, NUM_REGS, ZERO_REG, wb_req_t
// Revision    : 1.0 - initial release
// ============================================================================
package rf_ctrl_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  // Architectural register that always reads as zero; writes to it are dropped.
  localparam int ZERO_REG = 0;

  // One writeback request as presented by a producer.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage : rf_ctrl_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin arbiter. A lone requester always
//               wins; when both request, the pointer picks the winner and then
//               flips to favour the loser next time.
// Ports       : clk, rstn (async, active-low)
//               req[1:0]   - request per port
//               grant[1:0] - one-hot (or zero) grant, same cycle as req
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  // ptr_q == 0 : port 0 wins the next contested cycle
  logic ptr_q;
  logic ptr_d;

  always_comb begin
    grant = req;
    ptr_d = ptr_q;
    if (&req) begin
      grant = ptr_q ? 2'b10 : 2'b01;
      ptr_d = ~ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter
// Description : Shares the register file write port between the ALU writeback
//               (port 0) and the long-latency writeback (port 1), and keeps a
//               per-register busy scoreboard for outstanding long-latency
//               destinations used for decode hazard detection.
// Ports       : clk, rstn (async, active-low)
//               wb0_valid/reg/data -> wb0_ready   ALU writeback
//               wb1_valid/reg/data -> wb1_ready   long-latency writeback
//               alloc_valid/reg    -> alloc_ready long-latency issue
//               read_reg_1/2       -> busy_1/2    decode operand hazards
//               rf_reg_write, rf_write_reg, rf_write_data  register file port
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
  parameter int DATA_W   = rf_ctrl_pkg::DATA_W,
  parameter int ADDR_W   = rf_ctrl_pkg::ADDR_W,
  parameter int NUM_REGS = rf_ctrl_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wb0_valid,
  input  logic [ADDR_W-1:0] wb0_reg,
  input  logic [DATA_W-1:0] wb0_data,
  output logic              wb0_ready,
  input  logic              wb1_valid,
  input  logic [ADDR_W-1:0] wb1_reg,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              wb1_ready,
  input  logic              alloc_valid,
  input  logic [ADDR_W-1:0] alloc_reg,
  output logic              alloc_ready,
  input  logic [ADDR_W-1:0] read_reg_1,
  input  logic [ADDR_W-1:0] read_reg_2,
  output logic              busy_1,
  output logic              busy_2,
  output logic              rf_reg_write,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data
);

  import rf_ctrl_pkg::*;

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [1:0]          w_req;
  logic [1:0]          w_grant;
  logic                w_alloc_fire;

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  logic                rf_we_q;
  logic                rf_we_d;
  logic [ADDR_W-1:0]   rf_wr_q;
  logic [ADDR_W-1:0]   rf_wr_d;
  logic [DATA_W-1:0]   rf_wd_q;
  logic [DATA_W-1:0]   rf_wd_d;

  // --------------------------------------------------------------------------
  // Eligibility. An ALU write to a register with a long-latency result still
  // in flight is held off, otherwise the late result would overwrite it.
  // Requests are masked during reset so grants drop as soon as rstn falls.
  // --------------------------------------------------------------------------
  always_comb begin
    w_req[0] = rstn & wb0_valid & ~busy_q[wb0_reg];
    w_req[1] = rstn & wb1_valid;
  end

  rr_arb2 u_arb (
    .clk   (clk),
    .rstn  (rstn),
    .req   (w_req),
    .grant (w_grant)
  );

  assign wb0_ready = w_grant[0];
  assign wb1_ready = w_grant[1];

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  // Register 0 never becomes busy, so allocations to it are always accepted
  // and simply not tracked.
  assign alloc_ready  = ~busy_q[alloc_reg] | (alloc_reg == ZERO_ADDR);
  assign w_alloc_fire = alloc_valid & alloc_ready & (alloc_reg != ZERO_ADDR);

  // Clear and set cannot target the same register in one cycle: a set needs
  // the bit clear, a clear only matters when the bit is set.
  always_comb begin
    busy_d    = busy_q;
    busy_d[0] = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (w_grant[1] && (wb1_reg == ADDR_W'(i))) begin
        busy_d[i] = 1'b0;
      end
      if (w_alloc_fire && (alloc_reg == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end
    end
  end

  assign busy_1 = busy_q[read_reg_1];
  assign busy_2 = busy_q[read_reg_2];

  // --------------------------------------------------------------------------
  // Register file write port, one cycle after the handshake. Address and data
  // keep their last values when idle; only the strobe returns low.
  // --------------------------------------------------------------------------
  always_comb begin
    rf_we_d = 1'b0;
    rf_wr_d = rf_wr_q;
    rf_wd_d = rf_wd_q;
    if (w_grant[0]) begin
      rf_we_d = (wb0_reg != ZERO_ADDR);
      rf_wr_d = wb0_reg;
      rf_wd_d = wb0_data;
    end else if (w_grant[1]) begin
      rf_we_d = (wb1_reg != ZERO_ADDR);
      rf_wr_d = wb1_reg;
      rf_wd_d = wb1_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q  <= '0;
      rf_we_q <= 1'b0;
      rf_wr_q <= '0;
      rf_wd_q <= '0;
    end else begin
      busy_q  <= busy_d;
      rf_we_q <= rf_we_d;
      rf_wr_q <= rf_wr_d;
      rf_wd_q <= rf_wd_d;
    end
  end

  assign rf_reg_write  = rf_we_q;
  assign rf_write_reg  = rf_wr_q;
  assign rf_write_data = rf_wd_q;

endmodule : rf_wb_arbiter
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wb_arbiter
// Description : Self-checking bench for rf_wb_arbiter: directed scenarios
//               followed by randomized traffic, compared against a behavioural
//               model of the arbiter, scoreboard and write port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wb0_valid, wb1_valid, alloc_valid;
  logic [4:0]  wb0_reg, wb1_reg, alloc_reg, read_reg_1, read_reg_2;
  logic [31:0] wb0_data, wb1_data;
  logic        wb0_ready, wb1_ready, alloc_ready, busy_1, busy_2;
  logic        rf_reg_write;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk           (clk),
    .rstn          (rstn),
    .wb0_valid     (wb0_valid),
    .wb0_reg       (wb0_reg),
    .wb0_data      (wb0_data),
    .wb0_ready     (wb0_ready),
    .wb1_valid     (wb1_valid),
    .wb1_reg       (wb1_reg),
    .wb1_data      (wb1_data),
    .wb1_ready     (wb1_ready),
    .alloc_valid   (alloc_valid),
    .alloc_reg     (alloc_reg),
    .alloc_ready   (alloc_ready),
    .read_reg_1    (read_reg_1),
    .read_reg_2    (read_reg_2),
    .busy_1        (busy_1),
    .busy_2        (busy_2),
    .rf_reg_write  (rf_reg_write),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: set of busy registers, whose turn it is on contention,
  // and the last write presented to the register file.
  bit          m_busy [32];
  bit          m_turn;       // port that wins the next contested cycle
  bit          m_we;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_turn = 1'b0;
    m_we   = 1'b0;
    m_wr   = '0;
    m_wd   = '0;
  endtask

  task automatic idle();
    wb0_valid = 0; wb0_reg = 0; wb0_data = 0;
    wb1_valid = 0; wb1_reg = 0; wb1_data = 0;
    alloc_valid = 0; alloc_reg = 0;
    read_reg_1 = 0; read_reg_2 = 0;
  endtask

  // Called shortly after a rising edge with inputs already applied. Checks the
  // combinational outputs, advances one clock, updates the model and checks
  // the registered write port.
  task automatic cycle();
    bit r0, r1, g0, g1, ar;
    #2;
    r0 = wb0_valid && !m_busy[wb0_reg];
    r1 = wb1_valid;
    if (r0 && r1) begin
      g0 = (m_turn == 1'b0);
      g1 = (m_turn == 1'b1);
    end else begin
      g0 = r0;
      g1 = r1;
    end
    ar = !m_busy[alloc_reg] || (alloc_reg == 0);
    chk("wb0_ready",   wb0_ready,   g0);
    chk("wb1_ready",   wb1_ready,   g1);
    chk("alloc_ready", alloc_ready, ar);
    chk("busy_1",      busy_1,      m_busy[read_reg_1]);
    chk("busy_2",      busy_2,      m_busy[read_reg_2]);
    @(posedge clk);
    if (r0 && r1) m_turn = !m_turn;
    if (g0) begin
      m_we = (wb0_reg != 0); m_wr = wb0_reg; m_wd = wb0_data;
    end else if (g1) begin
      m_we = (wb1_reg != 0); m_wr = wb1_reg; m_wd = wb1_data;
    end else begin
      m_we = 1'b0;
    end
    if (g1) m_busy[wb1_reg] = 1'b0;
    if (alloc_valid && ar && alloc_reg != 0) m_busy[alloc_reg] = 1'b1;
    #1;
    chk("rf_reg_write",  rf_reg_write,  m_we);
    chk("rf_write_reg",  rf_write_reg,  m_wr);
    chk("rf_write_data", rf_write_data, m_wd);
  endtask

  initial begin
    idle();
    model_reset();
    rstn = 1'b0;
    #12;
    chk("rst_we",    rf_reg_write,  1'b0);
    chk("rst_wr",    rf_write_reg,  5'd0);
    chk("rst_wd",    rf_write_data, 32'd0);
    chk("rst_busy1", busy_1,        1'b0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Contention from reset: grants alternate starting with port 0.
    wb0_valid = 1; wb0_reg = 5'd1;
    wb1_valid = 1; wb1_reg = 5'd2;
    for (int i = 0; i < 4; i++) begin
      wb0_data = 32'h100 + i;
      wb1_data = 32'h200 + i;
      #1;
      chk("cont_g0", wb0_ready, (i % 2) == 0);
      chk("cont_g1", wb1_ready, (i % 2) == 1);
      cycle();
      chk("cont_wr", rf_write_reg, (i % 2) == 0 ? 5'd1 : 5'd2);
    end
    idle();

    // Single ALU write.
    wb0_valid = 1; wb0_reg = 5'd5; wb0_data = 32'h0000_00AA;
    cycle();
    chk("single_we", rf_reg_write,  1'b1);
    chk("single_wr", rf_write_reg,  5'd5);
    chk("single_wd", rf_write_data, 32'hAA);
    idle();

    // Write to register 0 completes but is not forwarded.
    wb1_valid = 1; wb1_reg = 5'd0; wb1_data = 32'hFFFF_FFFF;
    #1;
    chk("zero_rdy", wb1_ready, 1'b1);
    cycle();
    chk("zero_we", rf_reg_write, 1'b0);
    idle();

    // Scoreboard hazard on register 7.
    alloc_valid = 1; alloc_reg = 5'd7;
    cycle();
    idle();
    read_reg_1 = 5'd7;
    wb0_valid = 1; wb0_reg = 5'd7; wb0_data = 32'h77;
    #1;
    chk("sb_busy",  busy_1,    1'b1);
    chk("sb_block", wb0_ready, 1'b0);
    cycle();
    wb1_valid = 1; wb1_reg = 5'd7; wb1_data = 32'h7777;
    cycle();
    chk("sb_wd", rf_write_data, 32'h7777);
    wb1_valid = 0;
    #1;
    chk("sb_clear", busy_1,    1'b0);
    chk("sb_accept", wb0_ready, 1'b1);
    cycle();
    idle();

    // Allocation conflicts on register 9.
    read_reg_1 = 5'd9;
    alloc_valid = 1; alloc_reg = 5'd9;
    cycle();
    #1;
    chk("alloc_again", alloc_ready, 1'b0);
    cycle();
    wb1_valid = 1; wb1_reg = 5'd9; wb1_data = 32'h99;
    #1;
    chk("alloc_vs_clr", alloc_ready, 1'b0);
    cycle();
    chk("alloc_clr_busy", busy_1, 1'b0);
    idle();

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      wb0_valid   = ($urandom_range(0, 99) < 60);
      wb0_reg     = 5'($urandom_range(0, 7));
      wb0_data    = $urandom;
      wb1_valid   = ($urandom_range(0, 99) < 40);
      wb1_reg     = 5'($urandom_range(0, 7));
      wb1_data    = $urandom;
      alloc_valid = ($urandom_range(0, 99) < 35);
      alloc_reg   = 5'($urandom_range(0, 7));
      read_reg_1  = 5'($urandom_range(0, 7));
      read_reg_2  = 5'($urandom_range(0, 31));
      cycle();
    end
    idle();
    @(posedge clk); #1;
    m_we = 1'b0;

    // Reset in the middle of a handshake.
    alloc_valid = 1; alloc_reg = 5'd3;
    cycle();
    idle();
    wb0_valid = 1; wb0_reg = 5'd4; wb0_data = 32'h4444;
    read_reg_1 = 5'd3;
    cycle();
    chk("mid_we_pre", rf_reg_write, 1'b1);
    #1;
    rstn = 1'b0;
    #1;
    chk("mid_we",    rf_reg_write, 1'b0);
    chk("mid_rdy",   wb0_ready,    1'b0);
    chk("mid_busy1", busy_1,       1'b0);
    model_reset();
    @(posedge clk); #1;
    wb0_valid = 0;
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_we", rf_reg_write, 1'b0);
    for (int n = 0; n < 20; n++) begin
      wb0_valid   = $urandom_range(0, 1);
      wb0_reg     = 5'($urandom_range(0, 7));
      wb0_data    = $urandom;
      wb1_valid   = $urandom_range(0, 1);
      wb1_reg     = 5'($urandom_range(0, 7));
      wb1_data    = $urandom;
      alloc_valid = $urandom_range(0, 1);
      alloc_reg   = 5'($urandom_range(0, 7));
      read_reg_1  = 5'($urandom_range(0, 7));
      read_reg_2  = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_rf_wb_arbiter
`default_nettype wire
